// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the sequential matrix multiplier.
package matmul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StDone
  } state_e;

  localparam int unsigned DefMatSize = 2;
  localparam int unsigned DefDatSize = 8;

  // Wide enough that a full non-accumulating dot product never overflows.
  function automatic int unsigned acc_width(input int unsigned n, input int unsigned d);
    return 2 * d + $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_if.sv
// Operand/result bus and start/busy/done handshake of the matrix multiplier.
interface matmul_if
  import matmul_pkg::*;
#(
  parameter int unsigned MAT_SIZE = DefMatSize,
  parameter int unsigned DAT_SIZE = DefDatSize,
  parameter int unsigned ACC_SIZE = acc_width(MAT_SIZE, DAT_SIZE)
);

  logic                                             start;
  logic                                             signed_mode;
  logic                                             acc_mode;
  logic [MAT_SIZE-1:0][MAT_SIZE-1:0][DAT_SIZE-1:0] mat_A;
  logic [MAT_SIZE-1:0][MAT_SIZE-1:0][DAT_SIZE-1:0] mat_B;
  logic [MAT_SIZE-1:0][MAT_SIZE-1:0][ACC_SIZE-1:0] mat_C;
  logic                                             busy;
  logic                                             done;

  modport master (
    output start, signed_mode, acc_mode, mat_A, mat_B,
    input  mat_C, busy, done
  );

  modport slave (
    input  start, signed_mode, acc_mode, mat_A, mat_B,
    output mat_C, busy, done
  );

endinterface

// File: rtl/matmul_mac.sv
// Combinational multiply-add with per-run sign or zero extension of both operands.
module matmul_mac #(
  parameter int unsigned DAT_SIZE = 8,
  parameter int unsigned ACC_SIZE = 17
) (
  input  logic [DAT_SIZE-1:0] op_a,
  input  logic [DAT_SIZE-1:0] op_b,
  input  logic [ACC_SIZE-1:0] acc_in,
  input  logic                signed_mode,
  output logic [ACC_SIZE-1:0] acc_out
);

  logic [ACC_SIZE-1:0] ext_a;
  logic [ACC_SIZE-1:0] ext_b;

  // Truncated product of extended operands is exact modulo 2^ACC_SIZE in both modes.
  always_comb begin
    ext_a   = {{(ACC_SIZE - DAT_SIZE){signed_mode & op_a[DAT_SIZE-1]}}, op_a};
    ext_b   = {{(ACC_SIZE - DAT_SIZE){signed_mode & op_b[DAT_SIZE-1]}}, op_b};
    acc_out = acc_in + ext_a * ext_b;
  end

endmodule

// File: rtl/matmul_seq.sv
// Sequential N x N matrix multiplier: one shared MAC walked over i, j, k (k innermost).
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int unsigned MAT_SIZE = DefMatSize,
  parameter int unsigned DAT_SIZE = DefDatSize,
  parameter int unsigned ACC_SIZE = acc_width(MAT_SIZE, DAT_SIZE)
) (
  input logic     clk,
  input logic     rst_n,
  matmul_if.slave bus
);

  localparam int unsigned IdxW = $clog2(MAT_SIZE);
  localparam logic [IdxW-1:0] Last = IdxW'(MAT_SIZE - 1);

  typedef logic [MAT_SIZE-1:0][MAT_SIZE-1:0][DAT_SIZE-1:0] op_mat_t;
  typedef logic [MAT_SIZE-1:0][MAT_SIZE-1:0][ACC_SIZE-1:0] res_mat_t;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
  op_mat_t             a_q, a_d, b_q, b_d;
  logic                signed_q, signed_d, accm_q, accm_d;
  logic [ACC_SIZE-1:0] acc_q, acc_d, mac_out;
  res_mat_t            c_q, c_d;

  matmul_mac #(
    .DAT_SIZE(DAT_SIZE),
    .ACC_SIZE(ACC_SIZE)
  ) u_mac (
    .op_a       (a_q[i_q][k_q]),
    .op_b       (b_q[k_q][j_q]),
    .acc_in     (acc_q),
    .signed_mode(signed_q),
    .acc_out    (mac_out)
  );

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    accm_d   = accm_q;
    acc_d    = acc_q;
    c_d      = c_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StMac;
          a_d      = bus.mat_A;
          b_d      = bus.mat_B;
          signed_d = bus.signed_mode;
          accm_d   = bus.acc_mode;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          acc_d    = '0;
        end
      end
      StMac: begin
        if (k_q == Last) begin
          // Dot product complete: retire it into C and move on in row-major order.
          c_d[i_q][j_q] = mac_out + (accm_q ? c_q[i_q][j_q] : '0);
          acc_d         = '0;
          k_d           = '0;
          if (j_q == Last) begin
            j_d = '0;
            if (i_q == Last) begin
              i_d     = '0;
              state_d = StDone;
            end else begin
              i_d = i_q + IdxW'(1);
            end
          end else begin
            j_d = j_q + IdxW'(1);
          end
        end else begin
          acc_d = mac_out;
          k_d   = k_q + IdxW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      accm_q   <= 1'b0;
      acc_q    <= '0;
      c_q      <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      accm_q   <= accm_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
    end
  end

  assign bus.mat_C = c_q;
  assign bus.busy  = (state_q == StMac);
  assign bus.done  = (state_q == StDone);

endmodule

// File: tb/tb_matmul_seq.sv
// Self-checking bench for matmul_seq: directed and random runs against an arithmetic model.
module tb_matmul_seq;
  import matmul_pkg::*;

  localparam int unsigned N   = 2;
  localparam int unsigned D   = 8;
  localparam int unsigned ACC = acc_width(N, D);
  localparam int          LAT = N * N * N;

  typedef logic [N-1:0][N-1:0][D-1:0]   opm_t;
  typedef logic [N-1:0][N-1:0][ACC-1:0] resm_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  matmul_if #(.MAT_SIZE(N), .DAT_SIZE(D), .ACC_SIZE(ACC)) bus ();

  matmul_seq #(.MAT_SIZE(N), .DAT_SIZE(D), .ACC_SIZE(ACC)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int    total = 0;
  int    bad   = 0;
  resm_t exp_c;
  opm_t  cur_a, cur_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ext(input logic [D-1:0] v, input bit sm);
    int e;
    e = int'(v);
    if (sm && v[D-1]) e -= (1 << D);
    return e;
  endfunction

  // Plain matrix product, reduced modulo 2^ACC at the end.
  task automatic model(input bit sm, input bit am);
    longint s;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += longint'(ext(cur_a[i][k], sm) * ext(cur_b[k][j], sm));
        exp_c[i][j] = (am ? exp_c[i][j] : '0) + ACC'(s);
      end
    end
  endtask

  task automatic check_c(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("%s_c%0d%0d", tag, i, j), bus.mat_C[i][j], exp_c[i][j]);
  endtask

  task automatic set_test1();
    cur_a[0][0] = 8'd1; cur_a[0][1] = 8'd2; cur_a[1][0] = 8'd3; cur_a[1][1] = 8'd4;
    cur_b[0][0] = 8'd5; cur_b[0][1] = 8'd6; cur_b[1][0] = 8'd7; cur_b[1][1] = 8'd8;
  endtask

  // One full run: start for one cycle, optional mid-run start pulse and operand scrambling.
  task automatic run(input string tag, input bit sm, input bit am, input int mid_start,
                     input bit scramble);
    int cyc, busy_n;
    bit seen;
    bus.mat_A       = cur_a;
    bus.mat_B       = cur_b;
    bus.signed_mode = sm;
    bus.acc_mode    = am;
    bus.start       = 1'b1;
    model(sm, am);
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc    = 0;
    busy_n = bus.busy ? 1 : 0;
    seen   = 1'b0;
    while (!seen && cyc < 50) begin
      if (scramble && cyc == 1) begin
        bus.mat_A       = ~cur_a;
        bus.mat_B       = ~cur_b;
        bus.signed_mode = ~sm;
        bus.acc_mode    = ~am;
      end
      if (cyc == mid_start) bus.start = 1'b1;
      if (cyc == mid_start + 1) bus.start = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (bus.done) seen = 1'b1;
      else if (bus.busy) busy_n++;
    end
    check({tag, "_latency"}, cyc, LAT);
    check({tag, "_busy_cycles"}, busy_n, LAT);
    check({tag, "_busy_at_done"}, bus.busy, 1'b0);
    check_c(tag);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, bus.done, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int cyc, dones, first, second;
    bit sm, am;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.acc_mode    = 1'b0;
    bus.mat_A       = '0;
    bus.mat_B       = '0;
    exp_c           = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check_c("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic unsigned product
    set_test1();
    run("t1", 1'b0, 1'b0, -1, 1'b0);

    // Signed operands against identity, then the same bits unsigned
    cur_a[0][0] = 8'hFF; cur_a[0][1] = 8'd2; cur_a[1][0] = 8'd3; cur_a[1][1] = 8'hFC;
    cur_b[0][0] = 8'd1;  cur_b[0][1] = 8'd0; cur_b[1][0] = 8'd0; cur_b[1][1] = 8'd1;
    run("t2s", 1'b1, 1'b0, -1, 1'b0);
    check("t2s_neg1", bus.mat_C[0][0], 17'h1FFFF);
    run("t2u", 1'b0, 1'b0, -1, 1'b0);
    check("t2u_255", bus.mat_C[0][0], 17'd255);

    // Maximum unsigned, then accumulate wraps
    cur_a = '1;
    cur_b = '1;
    run("t3", 1'b0, 1'b0, -1, 1'b0);
    check("t3_max", bus.mat_C[1][1], 17'd130050);
    run("t3acc", 1'b0, 1'b1, -1, 1'b0);
    check("t3acc_wrap", bus.mat_C[0][1], 17'd129028);

    // Accumulate after test 1, then plain rerun
    set_test1();
    run("t4a", 1'b0, 1'b0, -1, 1'b0);
    run("t4b", 1'b0, 1'b1, -1, 1'b0);
    check("t4b_c11", bus.mat_C[1][1], 17'd100);
    run("t4c", 1'b0, 1'b0, -1, 1'b0);
    check("t4c_c00", bus.mat_C[0][0], 17'd19);

    // Start while busy ignored; inputs changed after accept ignored
    run("t5", 1'b0, 1'b0, 3, 1'b1);

    // Held start: back-to-back runs, one done each
    set_test1();
    bus.mat_A       = cur_a;
    bus.mat_B       = cur_b;
    bus.signed_mode = 1'b0;
    bus.acc_mode    = 1'b0;
    model(1'b0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    cyc = 0; dones = 0; first = 0; second = 0;
    while (dones < 2 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) begin
        dones++;
        if (dones == 1) first = cyc;
        else begin
          second    = cyc;
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    check("t5h_first_done", first, LAT);
    check("t5h_gap", second - first, LAT + 2);
    check_c("t5h");
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dones++;
    end
    check("t5h_quiet_after", dones, 0);

    // Reset mid-run clears results asynchronously
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    exp_c = '0;
    check("t6_busy", bus.busy, 1'b0);
    check("t6_done", bus.done, 1'b0);
    check_c("t6_rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run("t6_after", 1'b0, 1'b1, -1, 1'b0);

    // Random runs, modes chosen per run
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          cur_a[i][j] = D'($urandom);
          cur_b[i][j] = D'($urandom);
        end
      sm = 1'($urandom);
      am = 1'($urandom);
      run($sformatf("rnd%0d", r), sm, am, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
